prio_arbiter_n: RTL

PRIO_ARBITER_N -- requirements
Module: prio_arbiter_n

---
 rtl/prio_arbiter_n.sv | 126 ++++++++++++
 1 files changed

// File: rtl/prio_arbiter_n.sv
// Parameterised priority arbiter with fixed-priority and round-robin modes.
// A registered one-hot grant (plus binary code) is presented until acked;
// on ack the block re-arbitrates in the same cycle so grants can run
// back-to-back without a bubble.
module prio_arbiter_n #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         ack,
  output logic [N-1:0] grant,
  output logic [W-1:0] code,
  output logic         valid,
  output logic         multi
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t       r_state, w_state_nxt;
  logic [W-1:0] r_ptr, w_ptr_nxt;
  logic [N-1:0] r_grant, w_grant_nxt;
  logic [W-1:0] r_code, w_code_nxt;
  logic         r_multi, w_multi_nxt;

  logic [W-1:0] w_start;
  logic [W-1:0] w_win_code;
  logic [N-1:0] w_win_grant;
  logic         w_found;
  logic         w_any;
  logic         w_arb_multi;

  assign w_any       = |req;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign w_arb_multi = |(req & (req - N'(1)));

  // Pointer update: only an ack in round-robin mode moves it, to one below
  // the line just served. The subtraction wraps 0 -> N-1 because N = 2**W.
  assign w_ptr_nxt = (r_state == GRANT && ack && mode) ? r_code - W'(1) : r_ptr;

  // Fixed mode is round-robin with the pointer pinned at the top index.
  assign w_start = mode ? w_ptr_nxt : W'(N - 1);

  // Downward search with wrap from the start index; the first set bit wins.
  always_comb begin
    // NOTE: every signal written here gets a default first, otherwise paths
    // that skip an assignment would infer a latch.
    w_win_code  = '0;
    w_win_grant = '0;
    w_found     = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && req[w_start - W'(k)]) begin
        w_win_code              = w_start - W'(k);
        w_win_grant             = '0;
        w_win_grant[w_win_code] = 1'b1;
        w_found                 = 1'b1;
      end
    end
  end

  // Next-state and next-output logic: load a new grant, hold, or clear.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_code_nxt  = r_code;
    w_multi_nxt = r_multi;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = GRANT;
          w_grant_nxt = w_win_grant;
          w_code_nxt  = w_win_code;
          w_multi_nxt = w_arb_multi;
        end
      end
      GRANT: begin
        if (ack) begin
          if (w_any) begin
            w_state_nxt = GRANT;
            w_grant_nxt = w_win_grant;
            w_code_nxt  = w_win_code;
            w_multi_nxt = w_arb_multi;
          end else begin
            w_state_nxt = IDLE;
            w_grant_nxt = '0;
            w_code_nxt  = '0;
            w_multi_nxt = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears the grant without a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= W'(N - 1);
      r_grant <= '0;
      r_code  <= '0;
      r_multi <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_grant <= w_grant_nxt;
      r_code  <= w_code_nxt;
      r_multi <= w_multi_nxt;
    end
  end

  assign grant = r_grant;
  assign code  = r_code;
  assign valid = (r_state == GRANT);
  assign multi = r_multi;

endmodule
